// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: FSM state encoding,
//   PC increment, canonical NOP and the packed {pc, instr} buffer entry.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // first cycle after reset release, no fetch
        ST_RUN   = 2'd1,   // fetching one word per cycle when buffer has room
        ST_FAULT = 2'd2    // misaligned redirect target, PC frozen
    } fetch_state_e;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam int          FETCH_ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO, DEPTH entries of W bits, combinational read of the head.
//   Flush has priority over push and pop. Simultaneous push+pop is legal when
//   full: the head is read before the write lands on the same slot.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   push, pop  : write din at tail / retire head
//   flush      : empty the FIFO (pointers and count to zero)
//   din, dout  : write data / head data
//   count      : number of valid entries, $clog2(DEPTH)+1 bits
//   full, empty: occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // NOTE: the storage is reset as well, so the head outputs read zero out of
    // reset; this is cheap at this depth and makes reset values deterministic.
    // NOTE: every state element is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);   // wraps modulo DEPTH
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, drives a combinational word-read
//   instruction memory port and buffers {pc, instr} pairs for decode.
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : byte address to instruction memory (always the PC)
//   imem_instr      : instruction word for imem_addr, same cycle
//   redirect_valid  : load redirect_pc into the PC and flush the buffer
//   redirect_pc     : redirect target byte address
//   fetch_valid     : buffer head holds an instruction
//   fetch_instr     : head instruction
//   fetch_pc        : PC of head instruction
//   fetch_ready     : decode accepts the head this cycle
//   fetch_misalign  : sticky, last redirect target was not word aligned
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
    output logic        fetch_misalign
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic [31:0]   r_pc;
    logic          r_misalign;

    logic          w_push;
    logic          w_pop;
    logic          w_pop_req;
    logic          w_redirect_bad;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_din;
    fetch_entry_t  w_dout;

    assign w_redirect_bad = (redirect_pc[1:0] != 2'b00);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment at the top keeps this block free of latches
    // whatever path the case statement takes.
    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            w_next_state = w_redirect_bad ? ST_FAULT : ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_RUN;
                ST_RUN:   w_next_state = ST_RUN;
                ST_FAULT: w_next_state = ST_FAULT;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    // A full buffer may still accept a push when the head leaves in the same
    // cycle; that keeps throughput at one word per cycle. A redirect kills
    // both the push and the pop (the flush discards the head anyway).
    always_comb begin
        w_pop_req = fetch_ready && !w_empty;
        w_pop     = w_pop_req && !redirect_valid;
        w_push    = (r_state == ST_RUN) && !redirect_valid && (!w_full || w_pop_req);
    end

    // ---------------- PC and sticky misalign flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_misalign <= w_redirect_bad;
        end else if (w_push) begin
            r_pc       <= r_pc + PC_STEP;   // wraps modulo 2^32
        end
    end

    assign w_din = '{pc: r_pc, instr: imem_instr};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign imem_addr      = r_pc;
    assign fetch_valid    = (w_count != '0);
    assign fetch_instr    = w_dout.instr;
    assign fetch_pc       = w_dout.pc;
    assign fetch_misalign = r_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Memory word at byte address a is
//   32'h1000_0000 + (a >> 2). A queue model of the fetch buffer predicts the
//   outputs; a compare process checks them on every falling edge, and
//   directed literal checks pin the scenario landmarks.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        fetch_misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Combinational instruction memory.
    assign imem_instr = mem_word(imem_addr);

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    bit          m_mis;
    bit          m_started;   // first cycle after reset is spent idle
    bit          m_fault;     // fetching suspended by a misaligned redirect

    function automatic void model_reset();
        m_q.delete();
        m_pc      = RESET_PC;
        m_mis     = 1'b0;
        m_started = 1'b0;
        m_fault   = 1'b0;
    endfunction

    function automatic void model_step();
        bit   pop;
        bit   room;
        ent_t e;
        pop = (m_q.size() != 0) && fetch_ready;
        if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_mis   = (redirect_pc[1:0] != 2'b00);
            m_fault = m_mis;
        end else begin
            room = (m_q.size() < DEPTH) || pop;
            if (pop) void'(m_q.pop_front());
            if (m_started && !m_fault && room) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        m_started = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(fetch_valid), 32'(m_q.size() != 0));
            check("imem_addr", imem_addr, m_pc);
            check("misalign", 32'(fetch_misalign), 32'(m_mis));
            if (m_q.size() != 0) begin
                check("head_pc", fetch_pc, m_q[0].pc);
                check("head_instr", fetch_instr, m_q[0].instr);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cyc();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values.
        cyc(2);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr", fetch_instr, 32'd0);
        check("rst_pc", fetch_pc, 32'd0);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);

        // 1: startup, one word per cycle.
        rst_n = 1'b1;
        cyc();
        check("s1_idle_valid", 32'(fetch_valid), 32'd0);
        cyc();
        check("s1_first_pc", fetch_pc, 32'h0000_0000);
        check("s1_first_instr", fetch_instr, 32'h1000_0000);
        cyc();
        check("s1_second_pc", fetch_pc, 32'h0000_0004);
        cyc();
        check("s1_third_pc", fetch_pc, 32'h0000_0008);

        // 2: stall five cycles, buffer saturates, PC holds.
        fetch_ready = 1'b0;
        cyc(5);
        check("s2_hold_pc", fetch_pc, 32'h0000_0008);
        check("s2_hold_addr", imem_addr, 32'h0000_0010);
        fetch_ready = 1'b1;
        cyc();
        check("s2_resume_pc0", fetch_pc, 32'h0000_000C);
        cyc();
        check("s2_resume_pc1", fetch_pc, 32'h0000_0010);

        // 3: redirect while full and popping.
        redirect(32'h0000_0100);
        check("s3_flush_valid", 32'(fetch_valid), 32'd0);
        cyc();
        check("s3_new_valid", 32'(fetch_valid), 32'd1);
        check("s3_new_pc", fetch_pc, 32'h0000_0100);
        cyc(3);

        // 4: misaligned redirect, then recovery.
        redirect(32'h0000_0102);
        check("s4_misalign_set", 32'(fetch_misalign), 32'd1);
        check("s4_fault_addr", imem_addr, 32'h0000_0102);
        cyc(3);
        check("s4_no_push", 32'(fetch_valid), 32'd0);
        redirect(32'h0000_0200);
        check("s4_misalign_clr", 32'(fetch_misalign), 32'd0);
        cyc();
        check("s4_recover_pc", fetch_pc, 32'h0000_0200);
        check("s4_recover_instr", fetch_instr, 32'h1000_0080);

        // Back-to-back redirects: only the last target is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        cyc();
        redirect(32'h0000_0400);
        check("b2b_valid", 32'(fetch_valid), 32'd0);
        cyc();
        check("b2b_pc", fetch_pc, 32'h0000_0400);

        // 5: PC wraps modulo 2^32.
        redirect(32'hFFFF_FFFC);
        cyc();
        check("s5_top_pc", fetch_pc, 32'hFFFF_FFFC);
        check("s5_top_instr", fetch_instr, 32'h4FFF_FFFF);
        cyc();
        check("s5_wrap_pc", fetch_pc, 32'h0000_0000);
        check("s5_wrap_instr", fetch_instr, 32'h1000_0000);
        cyc(2);

        // 6: asynchronous reset between edges.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("s6_async_valid", 32'(fetch_valid), 32'd0);
        check("s6_async_addr", imem_addr, RESET_PC);
        cyc(2);
        rst_n = 1'b1;
        cyc();
        check("s6_idle_valid", 32'(fetch_valid), 32'd0);
        cyc();
        check("s6_first_pc", fetch_pc, 32'h0000_0000);
        check("s6_first_instr", fetch_instr, 32'h1000_0000);
        cyc();
        check("s6_second_pc", fetch_pc, 32'h0000_0004);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
